// File: rtl/iomem_router.sv
// iomem_router: routes one SoC iomem transfer at a time to a decoded peripheral slot.
// Latency: iomem_ready at +1 (decode error), >= +2 (slot reply), at most +TIMEOUT+1.
// Backpressure: one outstanding transfer; new requests are accepted only in IDLE.
module iomem_router #(
  parameter logic [7:0]  REGION    = 8'h03,
  parameter int          SLOT_LSB  = 16,
  parameter int          SLOT_BITS = 2,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF,
  localparam int         NSLOTS    = 1 << SLOT_BITS
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  output logic [NSLOTS-1:0]   per_valid,
  output logic [3:0]          per_wstrb,
  output logic [31:0]         per_addr,
  output logic [31:0]         per_wdata,
  input  logic [NSLOTS-1:0]   per_ready,
  input  logic [32*NSLOTS-1:0] per_rdata,
  output logic                err_irq,
  output logic [31:0]         err_addr
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]     LAST = CW'(TIMEOUT - 1);
  localparam logic [NSLOTS-1:0] ONE  = NSLOTS'(1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  state_t                state;
  logic [SLOT_BITS-1:0]  slot;
  logic [CW-1:0]         cnt;
  logic [SLOT_BITS-1:0]  req_slot;
  logic [31:0]           slot_rdata;

  assign req_slot   = iomem_addr[SLOT_LSB +: SLOT_BITS];
  assign slot_rdata = per_rdata[32*slot +: 32];

  // Transfer sequencer; every output is set on the edge entering the state that presents it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      slot        <= '0;
      cnt         <= '0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      per_valid   <= '0;
      per_wstrb   <= '0;
      per_addr    <= '0;
      per_wdata   <= '0;
      err_irq     <= 1'b0;
      err_addr    <= '0;
    end else begin
      iomem_ready <= 1'b0;
      err_irq     <= 1'b0;
      case (state)
        IDLE: begin
          if (iomem_valid && !iomem_ready) begin
            per_addr  <= iomem_addr;
            per_wdata <= iomem_wdata;
            per_wstrb <= iomem_wstrb;
            slot      <= req_slot;
            if (iomem_addr[31:24] != REGION) begin
              // Out-of-region access never reaches a peripheral.
              iomem_ready <= 1'b1;
              iomem_rdata <= ERR_DATA;
              err_irq     <= 1'b1;
              err_addr    <= iomem_addr;
              state       <= ERR;
            end else begin
              per_valid <= ONE << req_slot;
              cnt       <= '0;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // A reply on the final allowed cycle takes priority over the timeout.
          if (per_ready[slot]) begin
            iomem_rdata <= slot_rdata;
            per_valid   <= '0;
            iomem_ready <= 1'b1;
            state       <= RESP;
          end else if (cnt == LAST) begin
            per_valid   <= '0;
            iomem_rdata <= ERR_DATA;
            iomem_ready <= 1'b1;
            err_irq     <= 1'b1;
            err_addr    <= per_addr;
            state       <= ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_router.sv
// Testbench for iomem_router: directed vector table, reset-during-access sequence, random traffic.
// Expected results come from constants or a transaction-level latency/data model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_iomem_router;

  localparam int TO = 16;
  localparam logic [31:0] EDATA = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         resetn;
  logic         iomem_valid;
  logic         iomem_ready;
  logic [3:0]   iomem_wstrb;
  logic [31:0]  iomem_addr;
  logic [31:0]  iomem_wdata;
  logic [31:0]  iomem_rdata;
  logic [3:0]   per_valid;
  logic [3:0]   per_wstrb;
  logic [31:0]  per_addr;
  logic [31:0]  per_wdata;
  logic [3:0]   per_ready;
  logic [127:0] per_rdata;
  logic         err_irq;
  logic [31:0]  err_addr;

  int checks = 0;
  int errors = 0;

  iomem_router dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .per_valid(per_valid), .per_wstrb(per_wstrb), .per_addr(per_addr), .per_wdata(per_wdata),
    .per_ready(per_ready), .per_rdata(per_rdata), .err_irq(err_irq), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          d;      // cycle after acceptance in which per_ready[slot] pulses
    bit          stray;  // pulse a different slot's ready in cycle 1
    int          lat;
    logic [31:0] rdata;
    bit          err;
    int          pv;     // cycles with per_valid asserted
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: outcome depends only on region, reply delay and timeout.
  function automatic void model(input logic [31:0] addr, input int d, input logic [127:0] rd,
                                output int lat, output logic [31:0] rdata,
                                output bit err, output int pv);
    int s;
    s = int'(addr[17:16]);
    if (addr[31:24] != 8'h03) begin
      lat = 1; rdata = EDATA; err = 1'b1; pv = 0;
    end else if (d <= TO) begin
      lat = d + 1; rdata = rd[32*s +: 32]; err = 1'b0; pv = d;
    end else begin
      lat = TO + 1; rdata = EDATA; err = 1'b1; pv = TO;
    end
  endfunction

  // Called at a falling edge; returns at the falling edge after the iomem_ready cycle.
  task automatic run_txn(input vec_t v);
    logic [1:0] slot;
    bit         good, got;
    int         lat, pvc, bad;
    logic [31:0] rdata, eaddr;
    logic        eirq;
    slot = v.addr[17:16];
    good = (v.addr[31:24] == 8'h03);
    got = 1'b0; lat = 0; pvc = 0; bad = 0; rdata = '0; eaddr = '0; eirq = 1'b0;
    iomem_valid = 1'b1;
    iomem_addr  = v.addr;
    iomem_wdata = v.wdata;
    iomem_wstrb = v.wstrb;
    per_ready   = '0;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Scramble the request lines: the router must work from its latched copy.
        iomem_valid = 1'b0;
        iomem_addr  = $urandom;
        iomem_wdata = $urandom;
        iomem_wstrb = 4'($urandom);
      end
      if (iomem_ready) begin
        got = 1'b1; lat = c; rdata = iomem_rdata; eirq = err_irq; eaddr = err_addr;
        if (per_valid !== 4'b0) bad++;
        per_ready = '0;
        break;
      end
      if (per_valid !== (good ? (4'b0001 << slot) : 4'b0000)) bad++;
      if (per_valid !== 4'b0) pvc++;
      if (per_addr !== v.addr || per_wdata !== v.wdata || per_wstrb !== v.wstrb) bad++;
      per_ready = '0;
      if (c == v.d) per_ready[slot] = 1'b1;
      if (v.stray && c == 1) per_ready[slot ^ 2'd3] = 1'b1;
    end
    chk("ready_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(v.lat));
    chk("rdata", rdata, v.rdata);
    chk("err_irq", 32'(eirq), 32'(v.err));
    chk("per_valid_cycles", 32'(pvc), 32'(v.pv));
    chk("per_side_shape", 32'(bad), 32'd0);
    if (v.err) chk("err_addr", eaddr, v.addr);
    @(negedge clk);
    chk("ready_pulse_len", {30'b0, iomem_ready, err_irq}, 32'd0);
  endtask

  vec_t tbl[8];
  vec_t rv;
  logic [127:0] fixed_rd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fixed_rd = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'h0000_00A0};
    //            addr          wstrb  wdata         d   str lat rdata          err pv
    tbl[0] = '{32'h0301_0004, 4'h0, 32'h0,         1,  0,  2, 32'h1234_5678, 0,  1};
    tbl[1] = '{32'h0300_0000, 4'hF, 32'h0000_00A5, 3,  0,  4, 32'h0000_00A0, 0,  3};
    tbl[2] = '{32'h0200_0000, 4'h0, 32'h0,         1,  0,  1, EDATA,         1,  0};
    tbl[3] = '{32'h0303_0010, 4'h0, 32'h0,         99, 0, 17, EDATA,         1, 16};
    tbl[4] = '{32'h0303_0010, 4'h0, 32'h0,         16, 0, 17, 32'h3333_3333, 0, 16};
    tbl[5] = '{32'h0301_0000, 4'h0, 32'h0,         3,  1,  4, 32'h1234_5678, 0,  3};
    tbl[6] = '{32'hFF01_0000, 4'h3, 32'hCAFE_F00D, 1,  0,  1, EDATA,         1,  0};
    tbl[7] = '{32'h0302_0008, 4'h3, 32'h0000_1111, 2,  0,  3, 32'h2222_2222, 0,  2};

    resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = '0; iomem_addr = '0;
    iomem_wdata = '0; per_ready = '0; per_rdata = fixed_rd;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(iomem_ready), 32'd0);
    chk("rst_per_valid", 32'(per_valid), 32'd0);
    chk("rst_err_irq", 32'(err_irq), 32'd0);
    chk("rst_rdata", iomem_rdata, 32'd0);
    chk("rst_per_addr", per_addr, 32'd0);
    chk("rst_per_wdata", per_wdata, 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed vectors, issued back-to-back.
    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // Reset while a slot access is in flight.
    iomem_valid = 1'b1; iomem_addr = 32'h0302_0000; iomem_wstrb = 4'h0;
    @(posedge clk);
    @(negedge clk);
    iomem_valid = 1'b0;
    @(negedge clk);
    chk("mid_access_pv", 32'(per_valid), 32'h4);
    resetn = 1'b0;
    @(negedge clk);
    chk("reset_drop_pv", 32'(per_valid), 32'd0);
    chk("reset_no_ready", 32'(iomem_ready), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {30'b0, iomem_ready, err_irq}, 32'd0);
    run_txn(tbl[0]);

    // Random traffic against the transaction model.
    for (int n = 0; n < 40; n++) begin
      per_rdata = {$urandom, $urandom, $urandom, $urandom};
      rv.addr  = $urandom;
      if ($urandom_range(0, 3) != 0) rv.addr[31:24] = 8'h03;
      rv.wstrb = 4'($urandom);
      rv.wdata = $urandom;
      rv.d     = $urandom_range(1, 20);
      rv.stray = 1'($urandom);
      model(rv.addr, rv.d, per_rdata, rv.lat, rv.rdata, rv.err, rv.pv);
      run_txn(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
